// File: rtl/spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// spi_slave_ctrl
//
// SPI slave word engine. It sits behind an external synchroniser / edge
// detector, which delivers chip select, MOSI and one-cycle SCLK edge strobes
// that are already in the clk_i domain. Words are DATA_W bits long and are
// transferred MSB first in both directions. Back-to-back words under a
// continuous chip select are supported with no gap bits.
//
// Build option:
//   SPI_SLAVE_CPHA1_EN  defined   -> SPI mode 1: MOSI sampled on SCLK falling
//                                    edge, MISO changes on SCLK rising edge.
//                       undefined -> SPI mode 0: MOSI sampled on SCLK rising
//                                    edge, MISO changes on SCLK falling edge.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   cs_n_i      chip select, active low (pre-synchronised)
//   sclk_pe_i   one-cycle strobe on SCLK rising edge
//   sclk_ne_i   one-cycle strobe on SCLK falling edge
//   mosi_i      serial data in (pre-synchronised, aligned with the strobes)
//   miso_o      serial data out; 1 when not shifting
//   miso_oe_o   MISO output enable, registered ~cs_n_i
//   tx_data_i   next word to transmit
//   tx_valid_i  tx_data_i is valid
//   tx_ready_o  high for the single LOAD cycle; word taken if tx_valid_i high
//   rx_data_o   last complete received word, held until the next one
//   rx_valid_o  one-cycle pulse when rx_data_o updates
//   underrun_o  one-cycle pulse when IDLE_WORD was loaded for lack of data
//   busy_o      high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module spi_slave_ctrl #(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD = '1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cs_n_i,
  input  logic              sclk_pe_i,
  input  logic              sclk_ne_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              underrun_o,
  output logic              busy_o
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  state_e            state_q,   state_d;
  logic [DATA_W-1:0] tx_sr_q,   tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q,   rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              rx_valid_q, rx_valid_d;
  logic              oe_q,       oe_d;

  // Strobes arriving while chip select is high are discarded here, so the
  // datapath below never has to look at cs_n_i for them.
  logic sample_stb;
  logic shift_stb;

`ifdef SPI_SLAVE_CPHA1_EN
  // Mode 1: MISO stays at the idle level until the first rising edge of the
  // word; drv_q records that this edge has been seen.
  logic drv_q, drv_d;
  assign sample_stb = sclk_ne_i & ~cs_n_i;
  assign shift_stb  = sclk_pe_i & ~cs_n_i;
`else
  assign sample_stb = sclk_pe_i & ~cs_n_i;
  assign shift_stb  = sclk_ne_i & ~cs_n_i;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    rx_valid_d = 1'b0;
    oe_d       = ~cs_n_i;
`ifdef SPI_SLAVE_CPHA1_EN
    drv_d      = drv_q;
`endif

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!cs_n_i) state_d = LOAD;
      end

      LOAD: begin
        bit_cnt_d = '0;
        rx_sr_d   = '0;
        tx_sr_d   = tx_valid_i ? tx_data_i : IDLE_WORD;
`ifdef SPI_SLAVE_CPHA1_EN
        drv_d     = 1'b0;
`endif
        state_d   = SHIFT;
      end

      SHIFT: begin
        // The shift edge that arrives before any bit of this word has been
        // sampled belongs to the word boundary: in mode 0 it is the trailing
        // falling edge of the previous word, in mode 1 it is the edge that
        // first drives the MSB. Either way the MSB must not be shifted out.
        if (shift_stb) begin
          if (bit_cnt_q != '0) begin
            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
          end
`ifdef SPI_SLAVE_CPHA1_EN
          else begin
            drv_d = 1'b1;
          end
`endif
        end

        if (sample_stb) begin
          rx_sr_d   = {rx_sr_q[DATA_W-2:0], mosi_i};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = rx_sr_d;
            rx_valid_d = 1'b1;
            state_d    = LOAD;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Chip select release aborts from any state; a partial word never
    // reaches rx_data_q because rx_valid_d needs a gated sample strobe.
    if (cs_n_i) state_d = IDLE;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      state_q    <= IDLE;
      tx_sr_q    <= IDLE_WORD;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      oe_q       <= 1'b0;
`ifdef SPI_SLAVE_CPHA1_EN
      drv_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_valid_q <= rx_valid_d;
      oe_q       <= oe_d;
`ifdef SPI_SLAVE_CPHA1_EN
      drv_q      <= drv_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decodes of registered state)
  // ---------------------------------------------------------------------------
`ifdef SPI_SLAVE_CPHA1_EN
  assign miso_o = (state_q == SHIFT && drv_q) ? tx_sr_q[DATA_W-1] : 1'b1;
`else
  assign miso_o = (state_q == SHIFT) ? tx_sr_q[DATA_W-1] : 1'b1;
`endif

  assign miso_oe_o  = oe_q;
  assign tx_ready_o = (state_q == LOAD);
  assign underrun_o = (state_q == LOAD) && !tx_valid_i;
  assign busy_o     = (state_q != IDLE);
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_ctrl
//
// Directed bench for spi_slave_ctrl (DATA_W = 8). A behavioural SPI master
// drives SCLK strobes at clk/8 and collects MISO; a small monitor counts
// output pulses and records received words. Expected values are hand-derived
// constants. Follows SPI_SLAVE_CPHA1_EN to select the master's mode.
// -----------------------------------------------------------------------------
module tb_spi_slave_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       sclk_pe;
  logic       sclk_ne;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       underrun;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Monitor state
  int         rx_cnt       = 0;
  int         ready_cnt    = 0;
  int         underrun_cnt = 0;
  int         ready_mark   = 0;
  logic [7:0] rx_last      = '0;
  logic [7:0] rx_prev      = '0;

  // Snapshots and captured MISO words
  int         r0, v0, u0;
  logic [7:0] m1, m2;

  spi_slave_ctrl #(
    .DATA_W    (8),
    .IDLE_WORD (8'hFF)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cs_n_i     (cs_n),
    .sclk_pe_i  (sclk_pe),
    .sclk_ne_i  (sclk_ne),
    .mosi_i     (mosi),
    .miso_o     (miso),
    .miso_oe_o  (miso_oe),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .underrun_o (underrun),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Pulse counting on the rising edge sees the value held through the
  // preceding cycle, so each one-cycle pulse is counted exactly once.
  always @(posedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_prev = rx_last;
      rx_last = rx_data;
    end
    if (tx_ready) ready_cnt++;
    if (underrun) underrun_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Master clocks out nbits of mosi_w (MSB first) and returns the MISO bits
  // it sampled. Each bit takes 8 clk cycles. For a full word it also checks
  // rx_valid/rx_data one cycle after the final sampling strobe.
  task automatic spi_bits(input logic [7:0] mosi_w, input int nbits, output logic [7:0] miso_w);
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
`ifdef SPI_SLAVE_CPHA1_EN
      @(negedge clk);
      mosi    = mosi_w[7-i];
      if (i == 7) ready_mark = ready_cnt;
      sclk_pe = 1'b1;
      @(negedge clk);
      sclk_pe = 1'b0;
      repeat (2) @(negedge clk);
      miso_w[7-i] = miso;
      @(negedge clk);
      sclk_ne = 1'b1;
      @(negedge clk);
      sclk_ne = 1'b0;
      if (i == 7) begin
        check("rx_valid_latency", 32'(rx_valid), 32'd1);
        check("rx_data_at_valid", 32'(rx_data), 32'(mosi_w));
      end
      repeat (2) @(negedge clk);
`else
      @(negedge clk);
      mosi        = mosi_w[7-i];
      miso_w[7-i] = miso;
      if (i == 7) ready_mark = ready_cnt;
      repeat (2) @(negedge clk);
      sclk_pe = 1'b1;
      @(negedge clk);
      sclk_pe = 1'b0;
      if (i == 7) begin
        check("rx_valid_latency", 32'(rx_valid), 32'd1);
        check("rx_data_at_valid", 32'(rx_data), 32'(mosi_w));
      end
      repeat (3) @(negedge clk);
      sclk_ne = 1'b1;
      @(negedge clk);
      sclk_ne = 1'b0;
`endif
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    cs_n     = 1'b1;
    sclk_pe  = 1'b0;
    sclk_ne  = 1'b0;
    mosi     = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;

    // ---------------- Reset values ----------------
    repeat (3) @(negedge clk);
    check("rst_miso",     32'(miso),     32'd1);
    check("rst_miso_oe",  32'(miso_oe),  32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_rx_data",  32'(rx_data),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_miso", 32'(miso), 32'd1);

    // ---------------- Single word: TX 0xA5, RX 0x3C ----------------
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    r0 = ready_cnt; v0 = rx_cnt; u0 = underrun_cnt;
    cs_n = 1'b0;
    @(negedge clk);
    check("load_tx_ready", 32'(tx_ready), 32'd1);
    check("load_busy",     32'(busy),     32'd1);
    check("load_underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    check("shift_tx_ready", 32'(tx_ready), 32'd0);
    check("shift_miso_oe",  32'(miso_oe),  32'd1);
    spi_bits(8'h3C, 8, m1);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("a_miso_word",    32'(m1),                32'hA5);
    check("a_rx_data",      32'(rx_data),           32'h3C);
    check("a_rx_pulses",    32'(rx_cnt - v0),       32'd1);
    check("a_underruns",    32'(underrun_cnt - u0), 32'd0);
    check("a_ready_pulses", 32'(ready_mark - r0),   32'd1);
    check("a_busy_after",   32'(busy),              32'd0);
    check("a_miso_idle",    32'(miso),              32'd1);
    check("a_miso_oe_off",  32'(miso_oe),           32'd0);

    // ---------------- Back-to-back: TX 0x12,0x34 RX 0xF0,0x0F ----------------
    tx_data = 8'h12;
    r0 = ready_cnt; v0 = rx_cnt;
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    tx_data = 8'h34;
    spi_bits(8'hF0, 8, m1);
    spi_bits(8'h0F, 8, m2);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("b_miso_word1",   32'(m1),              32'h12);
    check("b_miso_word2",   32'(m2),              32'h34);
    check("b_rx_word1",     32'(rx_prev),         32'hF0);
    check("b_rx_word2",     32'(rx_last),         32'h0F);
    check("b_rx_pulses",    32'(rx_cnt - v0),     32'd2);
    check("b_ready_pulses", 32'(ready_mark - r0), 32'd2);

    // ---------------- Underrun: no TX data at LOAD ----------------
    tx_valid = 1'b0;
    tx_data  = 8'h77;
    v0 = rx_cnt; u0 = underrun_cnt;
    cs_n = 1'b0;
    @(negedge clk);
    check("c_underrun_load", 32'(underrun), 32'd1);
    @(negedge clk);
    tx_valid = 1'b1;
    spi_bits(8'h5A, 8, m1);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("c_miso_word",  32'(m1),                32'hFF);
    check("c_rx_data",    32'(rx_data),           32'h5A);
    check("c_rx_pulses",  32'(rx_cnt - v0),       32'd1);
    check("c_underruns",  32'(underrun_cnt - u0), 32'd1);

    // ---------------- Abort after 5 bits ----------------
    tx_data = 8'hA5;
    v0 = rx_cnt;
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    spi_bits(8'hFF, 5, m1);
    cs_n = 1'b1;
    @(negedge clk);
    check("d_busy_after_abort", 32'(busy),    32'd0);
    check("d_rx_data_held",     32'(rx_data), 32'h5A);
    // Strobe with chip select high must be ignored.
    mosi    = 1'b1;
    sclk_pe = 1'b1;
    @(negedge clk);
    sclk_pe = 1'b0;
    @(negedge clk);
    check("d_rx_no_pulse", 32'(rx_cnt - v0), 32'd0);
    check("d_busy_cs_hi",  32'(busy),        32'd0);
    tx_data = 8'hC3;
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    spi_bits(8'h96, 8, m1);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("d_miso_word", 32'(m1),          32'hC3);
    check("d_rx_data",   32'(rx_data),     32'h96);
    check("d_rx_pulses", 32'(rx_cnt - v0), 32'd1);

    // ---------------- Reset after 3 bits ----------------
    tx_data = 8'h3C;
    v0 = rx_cnt;
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    spi_bits(8'hAA, 3, m1);
    #2;
    rst_n = 1'b0;
    #1;
    check("e_rst_miso",     32'(miso),     32'd1);
    check("e_rst_miso_oe",  32'(miso_oe),  32'd0);
    check("e_rst_tx_ready", 32'(tx_ready), 32'd0);
    check("e_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("e_rst_underrun", 32'(underrun), 32'd0);
    check("e_rst_busy",     32'(busy),     32'd0);
    check("e_rst_rx_data",  32'(rx_data),  32'd0);
    cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("e_idle_wait",   32'(busy),        32'd0);
    check("e_no_rx_pulse", 32'(rx_cnt - v0), 32'd0);
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    spi_bits(8'h81, 8, m1);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("e_miso_word", 32'(m1),          32'h3C);
    check("e_rx_data",   32'(rx_data),     32'h81);
    check("e_rx_pulses", 32'(rx_cnt - v0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
